// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: writeback source select,
// load operation codes, FSM states and the RF write-gate helper.
package wb_stage_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

  // r0 is hardwired to zero, so a write aimed at it is dropped here
  function automatic logic wr_gate(input logic wr_en, input logic [4:0] wr);
    return wr_en && (wr != 5'd0);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword from the
// returned word and sign- or zero-extends it. Unknown ops pass the word through.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // pick the addressed lane, then extend according to the load op
  always_comb begin
    byte_v   = rdata[7:0];
    half_v   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext_data = rdata;
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (ld_op)
      LD_B:    ext_data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   ext_data = {24'd0, byte_v};
      LD_H:    ext_data = {{16{half_v[15]}}, half_v};
      LD_HU:   ext_data = {16'd0, half_v};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for load data with a
// timeout, and drives a single registered RF write port. wb_wR is forced to 0
// whenever no write happens, since the decoder forwards on register match alone.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | ready for MEM; non-load ops retire on the next edge
//   ST_WAIT | load accepted, waiting for dm_rvalid or timeout
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wR,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_pc4,
  input  logic [2:0]  mem_ld_op,
  input  logic [1:0]  mem_addr_lo,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_wR,
  output logic [31:0] wb_wD,
  output logic        wb_retire,
  output logic        wb_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  wb_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_wr_en_q, ld_wr_en_d;
  logic [4:0]    ld_wr_q, ld_wr_d;
  logic [2:0]    ld_op_q, ld_op_d;
  logic [1:0]    ld_addr_lo_q, ld_addr_lo_d;
  logic          we_q, we_d;
  logic [4:0]    wr_q, wr_d;
  logic [31:0]   wd_q, wd_d;
  logic          retire_q, retire_d;
  logic          err_q, err_d;
  logic [31:0]   ld_data;

  wb_stage_load_align u_load_align (
    .rdata    (dm_rdata),
    .ld_op    (ld_op_q),
    .addr_lo  (ld_addr_lo_q),
    .ext_data (ld_data)
  );

  // next state, load context capture, timeout count and write-port values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_wr_en_d   = ld_wr_en_q;
    ld_wr_d      = ld_wr_q;
    ld_op_d      = ld_op_q;
    ld_addr_lo_d = ld_addr_lo_q;
    we_d         = 1'b0;
    wr_d         = 5'd0;
    wd_d         = wd_q;
    retire_d     = 1'b0;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          if (mem_wb_sel == WB_LOAD) begin
            ld_wr_en_d   = mem_wr_en;
            ld_wr_d      = mem_wR;
            ld_op_d      = mem_ld_op;
            ld_addr_lo_d = mem_addr_lo;
            cnt_d        = '0;
            state_d      = ST_WAIT;
          end else begin
            we_d     = wr_gate(mem_wr_en, mem_wR);
            wr_d     = we_d ? mem_wR : 5'd0;
            wd_d     = (mem_wb_sel == WB_PC4) ? mem_pc4 : mem_alu_res;
            retire_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // returning data takes priority over a timeout in the same cycle
        if (dm_rvalid) begin
          we_d     = wr_gate(ld_wr_en_q, ld_wr_q);
          wr_d     = we_d ? ld_wr_q : 5'd0;
          wd_d     = ld_data;
          retire_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          retire_d = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, load context and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ld_wr_en_q   <= 1'b0;
      ld_wr_q      <= 5'd0;
      ld_op_q      <= LD_W;
      ld_addr_lo_q <= 2'd0;
      we_q         <= 1'b0;
      wr_q         <= 5'd0;
      wd_q         <= 32'd0;
      retire_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_wr_en_q   <= ld_wr_en_d;
      ld_wr_q      <= ld_wr_d;
      ld_op_q      <= ld_op_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      we_q         <= we_d;
      wr_q         <= wr_d;
      wd_q         <= wd_d;
      retire_q     <= retire_d;
      err_q        <= err_d;
    end
  end

  assign mem_ready = (state_q == ST_IDLE);
  assign wb_we     = we_q;
  assign wb_wR     = wr_q;
  assign wb_wD     = wd_q;
  assign wb_retire = retire_q;
  assign wb_err    = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/PC4 writes, r0 and no-write retires,
// load alignment, timeout abort, back-to-back issue and reset mid-load.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wr_en;
  logic [4:0]  mem_wR;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_pc4;
  logic [2:0]  mem_ld_op;
  logic [1:0]  mem_addr_lo;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        wb_we;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD;
  logic        wb_retire;
  logic        wb_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wR      (mem_wR),
    .mem_wb_sel  (mem_wb_sel),
    .mem_alu_res (mem_alu_res),
    .mem_pc4     (mem_pc4),
    .mem_ld_op   (mem_ld_op),
    .mem_addr_lo (mem_addr_lo),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata),
    .wb_we       (wb_we),
    .wb_wR       (wb_wR),
    .wb_wD       (wb_wD),
    .wb_retire   (wb_retire),
    .wb_err      (wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for a single cycle; outputs are sampled 1ns after the edge
  task automatic issue(input logic [1:0] sel, input logic wr_en, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [2:0] op, input logic [1:0] lo);
    mem_valid   = 1'b1;
    mem_wb_sel  = sel;
    mem_wr_en   = wr_en;
    mem_wR      = wr;
    mem_alu_res = alu;
    mem_pc4     = pc4;
    mem_ld_op   = op;
    mem_addr_lo = lo;
    step();
    mem_valid = 1'b0;
  endtask

  // issue a load, hold off data for `delay` cycles, then return `rdata`
  task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] lo,
                         input logic [4:0] wr, input int delay,
                         input logic [31:0] rdata, input logic [31:0] exp_wd);
    issue(WB_LOAD, 1'b1, wr, 32'h0, 32'h0, op, lo);
    chk({tag, "_ready_wait"}, 32'(mem_ready), 32'd0);
    chk({tag, "_we_wait"}, 32'(wb_we), 32'd0);
    for (int i = 0; i < delay - 1; i++) step();
    dm_rvalid = 1'b1;
    dm_rdata  = rdata;
    step();
    dm_rvalid = 1'b0;
    chk({tag, "_we"}, 32'(wb_we), 32'd1);
    chk({tag, "_wr"}, 32'(wb_wR), 32'(wr));
    chk({tag, "_wd"}, wb_wD, exp_wd);
    chk({tag, "_retire"}, 32'(wb_retire), 32'd1);
    chk({tag, "_ready"}, 32'(mem_ready), 32'd1);
  endtask

  logic [1:0]  b2b_sel [4] = '{WB_ALU, WB_PC4, WB_ALU, WB_PC4};
  logic [31:0] b2b_alu [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] b2b_pc4 [4] = '{32'h1000, 32'h1004, 32'h2004, 32'h2008};
  logic [31:0] b2b_exp [4] = '{32'h11, 32'h1004, 32'h33, 32'h2008};

  initial begin
    int cycles;
    rst_n = 1'b0;
    mem_valid = 1'b0; mem_wr_en = 1'b0; mem_wR = 5'd0; mem_wb_sel = WB_ALU;
    mem_alu_res = 32'd0; mem_pc4 = 32'd0; mem_ld_op = LD_W; mem_addr_lo = 2'd0;
    dm_rvalid = 1'b0; dm_rdata = 32'd0;
    repeat (2) step();

    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_wr", 32'(wb_wR), 32'd0);
    chk("rst_wd", wb_wD, 32'd0);
    chk("rst_retire", 32'(wb_retire), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // plain ALU write, then the pulse drops with wD held
    issue(WB_ALU, 1'b1, 5'd5, 32'h1234, 32'h0, LD_W, 2'd0);
    chk("alu_we", 32'(wb_we), 32'd1);
    chk("alu_wr", 32'(wb_wR), 32'd5);
    chk("alu_wd", wb_wD, 32'h1234);
    chk("alu_retire", 32'(wb_retire), 32'd1);
    step();
    chk("alu_we_drop", 32'(wb_we), 32'd0);
    chk("alu_retire_drop", 32'(wb_retire), 32'd0);
    chk("alu_wd_hold", wb_wD, 32'h1234);

    // r0 destination and wr_en=0 both retire without writing
    issue(WB_ALU, 1'b1, 5'd0, 32'hAAAA, 32'h0, LD_W, 2'd0);
    chk("r0_we", 32'(wb_we), 32'd0);
    chk("r0_wr", 32'(wb_wR), 32'd0);
    chk("r0_retire", 32'(wb_retire), 32'd1);
    issue(WB_ALU, 1'b0, 5'd7, 32'hBBBB, 32'h0, LD_W, 2'd0);
    chk("nowr_we", 32'(wb_we), 32'd0);
    chk("nowr_wr", 32'(wb_wR), 32'd0);
    chk("nowr_retire", 32'(wb_retire), 32'd1);

    // stray dm_rvalid while idle does nothing
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    step();
    dm_rvalid = 1'b0;
    chk("idle_rvalid_we", 32'(wb_we), 32'd0);
    chk("idle_rvalid_retire", 32'(wb_retire), 32'd0);
    chk("idle_rvalid_err", 32'(wb_err), 32'd0);

    // load alignment cases
    do_load("ldb",  LD_B,  2'd2, 5'd8,  3, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("ldbu", LD_BU, 2'd2, 5'd9,  3, 32'h0080_0000, 32'h0000_0080);
    do_load("ldhu", LD_HU, 2'd3, 5'd10, 1, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("ldh",  LD_H,  2'd0, 5'd11, 2, 32'h1234_8001, 32'hFFFF_8001);
    do_load("ldw",  LD_W,  2'd3, 5'd12, 2, 32'hBEEF_0000, 32'hBEEF_0000);
    do_load("ldb3", LD_B,  2'd3, 5'd13, 1, 32'h7F00_00FF, 32'h0000_007F);

    // timeout: retire arrives TIMEOUT edges after the accept edge
    issue(WB_LOAD, 1'b1, 5'd14, 32'h0, 32'h0, LD_W, 2'd0);
    cycles = 0;
    while (!wb_retire && cycles < 40) begin
      step();
      cycles++;
      if (!wb_retire) chk("to_err_early", 32'(wb_err), 32'd0);
    end
    chk("to_cycles", 32'(cycles), 32'd16);
    chk("to_we", 32'(wb_we), 32'd0);
    chk("to_wr", 32'(wb_wR), 32'd0);
    chk("to_err", 32'(wb_err), 32'd1);
    chk("to_ready", 32'(mem_ready), 32'd1);
    repeat (3) step();
    chk("to_err_sticky", 32'(wb_err), 32'd1);
    issue(WB_ALU, 1'b1, 5'd3, 32'h5555, 32'h0, LD_W, 2'd0);
    chk("post_to_we", 32'(wb_we), 32'd1);
    chk("post_to_wd", wb_wD, 32'h5555);

    // four back-to-back non-load ops, one write per cycle
    for (int i = 0; i < 4; i++) begin
      mem_valid   = 1'b1;
      mem_wb_sel  = b2b_sel[i];
      mem_wr_en   = 1'b1;
      mem_wR      = 5'(i + 1);
      mem_alu_res = b2b_alu[i];
      mem_pc4     = b2b_pc4[i];
      step();
      chk("b2b_we", 32'(wb_we), 32'd1);
      chk("b2b_wr", 32'(wb_wR), 32'(i + 1));
      chk("b2b_wd", wb_wD, b2b_exp[i]);
    end
    mem_valid = 1'b0;

    // reset while waiting on a load, then a late rvalid
    issue(WB_LOAD, 1'b1, 5'd9, 32'h0, 32'h0, LD_W, 2'd0);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_wd", wb_wD, 32'd0);
    chk("midrst_err", 32'(wb_err), 32'd0);
    chk("midrst_ready", 32'(mem_ready), 32'd1);
    step();
    rst_n = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
    step();
    dm_rvalid = 1'b0;
    chk("late_rvalid_we", 32'(wb_we), 32'd0);
    chk("late_rvalid_retire", 32'(wb_retire), 32'd0);
    chk("late_rvalid_wd", wb_wD, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
